// File: rtl/ila_mem_pkg.sv
// Shared types and constants for the memory-attached logic analyzer.
package ila_mem_pkg;

  localparam int NUM_PROBES = 16;
  localparam int PROBE_W    = 32;

  localparam logic TRIG_LEVEL = 1'b0;
  localparam logic TRIG_EDGE  = 1'b1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

  // One stored snapshot at the default word width.
  typedef struct packed {
    logic [NUM_PROBES-1:0][PROBE_W-1:0] word;
    logic                               flag;
  } sample_t;

endpackage

// File: rtl/ila_mem_core_if.sv
// Probe, control and readout bundle between the observed memory and the capture core.
interface ila_mem_core_if #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
);
  localparam int SAMPLE_AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] probe0, probe1, probe2, probe3;
  logic [DATA_WIDTH-1:0] probe4, probe5, probe6, probe7;
  logic [DATA_WIDTH-1:0] probe8, probe9, probe10, probe11;
  logic [DATA_WIDTH-1:0] probe12, probe13, probe14, probe15;
  logic                  probe16;
  logic                  arm;
  logic                  trig_mode;
  logic [SAMPLE_AW-1:0]  rd_sample;
  logic [3:0]            rd_probe;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_flag;
  logic                  armed;
  logic                  capturing;
  logic                  done;
  logic [SAMPLE_AW:0]    sample_count;

  modport master (
    output probe0, probe1, probe2, probe3, probe4, probe5, probe6, probe7,
           probe8, probe9, probe10, probe11, probe12, probe13, probe14, probe15,
           probe16, arm, trig_mode, rd_sample, rd_probe,
    input  rd_data, rd_flag, armed, capturing, done, sample_count
  );

  modport slave (
    input  probe0, probe1, probe2, probe3, probe4, probe5, probe6, probe7,
           probe8, probe9, probe10, probe11, probe12, probe13, probe14, probe15,
           probe16, arm, trig_mode, rd_sample, rd_probe,
    output rd_data, rd_flag, armed, capturing, done, sample_count
  );
endinterface

// File: rtl/ila_mem_sample_buffer.sv
// Snapshot storage: one write port, combinational word/flag read port. Never reset.
module ila_mem_sample_buffer
  import ila_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int SAMPLE_AW  = $clog2(DEPTH)
) (
  input  logic                                  clk,
  input  logic                                  we,
  input  logic [SAMPLE_AW-1:0]                  waddr,
  input  logic [NUM_PROBES-1:0][DATA_WIDTH-1:0] wwords,
  input  logic                                  wflag,
  input  logic [SAMPLE_AW-1:0]                  rd_sample,
  input  logic [3:0]                            rd_probe,
  output logic [DATA_WIDTH-1:0]                 rd_data,
  output logic                                  rd_flag
);

  logic [NUM_PROBES-1:0][DATA_WIDTH-1:0] words_mem [DEPTH];
  logic [DEPTH-1:0]                      flag_mem;

  always_ff @(posedge clk) begin
    if (we) begin
      words_mem[waddr] <= wwords;
      flag_mem[waddr]  <= wflag;
    end
  end

  assign rd_data = words_mem[rd_sample][rd_probe];
  assign rd_flag = flag_mem[rd_sample];

endmodule

// File: rtl/ila_mem_core.sv
// Logic analyzer on data memory: arm, trigger on write_en (level/edge), capture DEPTH snapshots.
// Optional ILA_MEM_STORAGE_QUAL_EN: while capturing, store only cycles with probe16 high.
module ila_mem_core
  import ila_mem_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic           clk,
  input  logic           rst,
  ila_mem_core_if.slave  bus
);

  localparam int SAMPLE_AW = $clog2(DEPTH);
  localparam int CNT_W     = SAMPLE_AW + 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  state_t                                state, state_next;
  logic [CNT_W-1:0]                      count, count_next;
  logic                                  prev16;
  logic                                  trig;
  logic                                  store;
  logic                                  we;
  logic [NUM_PROBES-1:0][DATA_WIDTH-1:0] snap;

  assign snap = {bus.probe15, bus.probe14, bus.probe13, bus.probe12,
                 bus.probe11, bus.probe10, bus.probe9,  bus.probe8,
                 bus.probe7,  bus.probe6,  bus.probe5,  bus.probe4,
                 bus.probe3,  bus.probe2,  bus.probe1,  bus.probe0};

  assign trig = (bus.trig_mode == TRIG_EDGE) ? (bus.probe16 & ~prev16) : bus.probe16;

`ifdef ILA_MEM_STORAGE_QUAL_EN
  assign store = bus.probe16;
`else
  assign store = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      prev16 <= 1'b0;
    end else begin
      state  <= state_next;
      count  <= count_next;
      prev16 <= bus.probe16;
    end
  end

  always_comb begin
    state_next = state;
    count_next = count;
    we         = 1'b0;
    case (state)
      IDLE: begin
        if (bus.arm) state_next = ARMED;
      end
      ARMED: begin
        // Count is always zero here, so the trigger sample lands at index 0.
        if (trig) begin
          we         = 1'b1;
          count_next = CNT_W'(1);
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        if (store) begin
          we         = 1'b1;
          count_next = count + CNT_W'(1);
          if (count == LAST_IDX) state_next = DONE;
        end
      end
      DONE: begin
        if (bus.arm) begin
          state_next = ARMED;
          count_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  ila_mem_sample_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .SAMPLE_AW  (SAMPLE_AW)
  ) u_buf (
    .clk       (clk),
    .we        (we),
    .waddr     (count[SAMPLE_AW-1:0]),
    .wwords    (snap),
    .wflag     (bus.probe16),
    .rd_sample (bus.rd_sample),
    .rd_probe  (bus.rd_probe),
    .rd_data   (bus.rd_data),
    .rd_flag   (bus.rd_flag)
  );

  assign bus.armed        = (state == ARMED);
  assign bus.capturing    = (state == CAPTURE);
  assign bus.done         = (state == DONE);
  assign bus.sample_count = count;

endmodule

// File: tb/tb_ila_mem_core.sv
// Directed bench for ila_mem_core; expectations adapt when ILA_MEM_STORAGE_QUAL_EN is defined.
module tb_ila_mem_core;

  localparam int DW    = 32;
  localparam int DEPTH = 16;

`ifdef ILA_MEM_STORAGE_QUAL_EN
  localparam int          EXP_EDGES = 31;
  localparam int          STRIDE    = 2;
  localparam logic        EXP_FLAG5 = 1'b1;
  localparam logic [31:0] EXP_CNT3  = 32'd2;
`else
  localparam int          EXP_EDGES = 16;
  localparam int          STRIDE    = 1;
  localparam logic        EXP_FLAG5 = 1'b0;
  localparam logic [31:0] EXP_CNT3  = 32'd3;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  ila_mem_core_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  ila_mem_core #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then move the counting probes so each edge sees a distinct value.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    bus.probe0 = 32'hA5A5_0000 + 32'(cyc);
    bus.probe1 = ~bus.probe0;
  endtask

  task automatic chk_status(input string tag, input logic a, input logic c, input logic d,
                            input logic [31:0] cnt);
    chk({tag, "_armed"}, 32'(bus.armed), 32'(a));
    chk({tag, "_capturing"}, 32'(bus.capturing), 32'(c));
    chk({tag, "_done"}, 32'(bus.done), 32'(d));
    chk({tag, "_count"}, 32'(bus.sample_count), cnt);
  endtask

  task automatic rd(input int s, input int p);
    bus.rd_sample = 4'(s);
    bus.rd_probe  = 4'(p);
    #1;
  endtask

  initial begin
    logic [31:0] tv, tv2, v0;
    int          edges;

    rst           = 1'b1;
    bus.arm       = 1'b0;
    bus.trig_mode = 1'b0;
    bus.probe16   = 1'b0;
    bus.rd_sample = '0;
    bus.rd_probe  = '0;
    bus.probe0    = 32'hA5A5_0000;
    bus.probe1    = ~bus.probe0;
    bus.probe2  = 32'h2222; bus.probe3  = 32'h3333; bus.probe4  = 32'h4444;
    bus.probe5  = 32'h5555; bus.probe6  = 32'h6666; bus.probe7  = 32'h7777;
    bus.probe8  = 32'h8888; bus.probe9  = 32'h9999; bus.probe10 = 32'hAAAA;
    bus.probe11 = 32'hBBBB; bus.probe12 = 32'hCCCC; bus.probe13 = 32'hDDDD;
    bus.probe14 = 32'hEEEE; bus.probe15 = 32'hFFFF;
    tick();
    tick();
    chk_status("reset", 1'b0, 1'b0, 1'b0, 32'd0);
    rst = 1'b0;

    // Idle with write_en toggling and no arm: nothing happens.
    for (int i = 0; i < 4; i++) begin
      bus.probe16 = ~bus.probe16;
      tick();
    end
    chk_status("idle_hold", 1'b0, 1'b0, 1'b0, 32'd0);

    // Level trigger.
    bus.probe16 = 1'b0;
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    tick();
    tick();
    chk_status("lvl_armed", 1'b1, 1'b0, 1'b0, 32'd0);
    bus.probe16 = 1'b1;
    tv = bus.probe0;
    tick();
    chk_status("lvl_trig", 1'b0, 1'b1, 1'b0, 32'd1);
    for (int i = 0; i < 4; i++) tick();
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    chk_status("arm_in_capture", 1'b0, 1'b1, 1'b0, 32'd6);
    for (int i = 0; i < 9; i++) tick();
    chk_status("lvl_15", 1'b0, 1'b1, 1'b0, 32'd15);
    tick();
    chk_status("lvl_done", 1'b0, 1'b0, 1'b1, 32'd16);
    rd(0, 0);
    chk("lvl_s0_p0", bus.rd_data, tv);
    chk("lvl_s0_flag", 32'(bus.rd_flag), 32'd1);
    rd(0, 1);
    chk("lvl_s0_p1", bus.rd_data, ~tv);
    rd(15, 0);
    chk("lvl_s15_p0", bus.rd_data, tv + 32'd15);
    rd(9, 15);
    chk("lvl_s9_p15", bus.rd_data, 32'hFFFF);

    // Re-arm from DONE in edge mode with write_en already high.
    bus.trig_mode = 1'b1;
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    chk_status("rearm", 1'b1, 1'b0, 1'b0, 32'd0);
    rd(15, 0);
    chk("rearm_old_s15", bus.rd_data, tv + 32'd15);
    tick();
    tick();
    chk_status("edge_high_wait", 1'b1, 1'b0, 1'b0, 32'd0);
    bus.probe16 = 1'b0;
    tick();
    chk_status("edge_low", 1'b1, 1'b0, 1'b0, 32'd0);
    bus.probe16 = 1'b1;
    tv2 = bus.probe0;
    tick();
    chk_status("edge_trig", 1'b0, 1'b1, 1'b0, 32'd1);
    rd(0, 0);
    chk("edge_s0_p0", bus.rd_data, tv2);
    chk("edge_s0_flag", 32'(bus.rd_flag), 32'd1);
    rd(1, 0);
    chk("edge_s1_stale", bus.rd_data, tv + 32'd1);

    // Reset in the middle of a capture.
    for (int i = 0; i < 6; i++) tick();
    chk_status("pre_rst", 1'b0, 1'b1, 1'b0, 32'd7);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_status("mid_rst", 1'b0, 1'b0, 1'b0, 32'd0);
    rd(3, 0);
    chk("mid_rst_s3", bus.rd_data, tv2 + 32'd3);
    rd(6, 1);
    chk("mid_rst_s6_p1", bus.rd_data, ~(tv2 + 32'd6));

    // Arm coinciding with write_en in IDLE, then alternating write_en.
    bus.trig_mode = 1'b0;
    bus.probe16 = 1'b1;
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    chk_status("idle_trig_ignored", 1'b1, 1'b0, 1'b0, 32'd0);
    v0 = bus.probe0;
    edges = 0;
    for (int i = 0; i < 40 && !bus.done; i++) begin
      bus.probe16 = (i % 2 == 0);
      tick();
      edges++;
      if (edges == 3) chk("alt_cnt3", 32'(bus.sample_count), EXP_CNT3);
    end
    chk("alt_edges", 32'(edges), 32'(EXP_EDGES));
    chk_status("alt_done", 1'b0, 1'b0, 1'b1, 32'd16);
    rd(5, 0);
    chk("alt_s5_p0", bus.rd_data, v0 + 32'(5 * STRIDE));
    chk("alt_s5_flag", 32'(bus.rd_flag), 32'(EXP_FLAG5));
    rd(15, 0);
    chk("alt_s15_p0", bus.rd_data, v0 + 32'(15 * STRIDE));
    rd(0, 0);
    chk("alt_s0_flag", 32'(bus.rd_flag), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
